axi4_bram_mem: RTL and testbench
================================

Name: axi4_bram_mem

Overview:
- AXI4 responder (slave) backed by an on-chip synchronous RAM of 64-bit words.
- Terminates the rocket system's memory master port (mem_axi4_0), which is currently tied off at the top level.
- Serves INCR and FIXED bursts with byte strobes, one transaction at a time.
- Reports DECERR for addresses outside its window and SLVERR for unsupported bursts.

Parameters:
- ID_W, 4, AXI ID width.
- ADDR_W, 32, AXI address width.
- DEPTH_LOG2, 14, log2 of the RAM word count; 16384 x 64 bit = 128 KiB.
- BASE_ADDR, 32'h8000_0000, window base; must be aligned to 2^(DEPTH_LOG2+3).

Ports:
- clock  in  1  single clock for all logic.
- resetn  in  1  synchronous reset, active-low.
- io_axi4_0_aw_valid / aw_ready  in / out  1 / 1  write-address handshake.
- io_axi4_0_aw_id / aw_addr / aw_len / aw_size / aw_burst  in  ID_W / ADDR_W / 8 / 3 / 2  write-address payload.
- io_axi4_0_w_valid / w_ready  in / out  1 / 1  write-data handshake.
- io_axi4_0_w_data / w_strb / w_last  in  64 / 8 / 1  write-data payload.
- io_axi4_0_b_valid / b_ready  out / in  1 / 1  write-response handshake.
- io_axi4_0_b_id / b_resp  out  ID_W / 2  write-response payload.
- io_axi4_0_ar_valid / ar_ready  in / out  1 / 1  read-address handshake.
- io_axi4_0_ar_id / ar_addr / ar_len / ar_size / ar_burst  in  ID_W / ADDR_W / 8 / 3 / 2  read-address payload.
- io_axi4_0_r_valid / r_ready  out / in  1 / 1  read-data handshake.
- io_axi4_0_r_id / r_data / r_resp / r_last  out  ID_W / 64 / 2 / 1  read-data payload.

Behaviour:
- Reset: resetn low at a clock edge puts the FSM in IDLE and clears the beat counter, all valid/ready outputs, and b_id, b_resp, r_id, r_data, r_resp, r_last.
- Reset: RAM contents are not cleared. Reset mid-burst abandons the burst; no response is issued.
- FSM states: IDLE, WDATA, WRESP, RFETCH, RDATA. Only one transaction is in flight.
- IDLE ready outputs: aw_ready=1 only when the write channel is granted; ar_ready=1 only when the read channel is granted.
- Arbitration: only one channel is granted at a time. If AW and AR are both valid, a round-robin pointer decides; it starts at write after reset and flips after each granted transaction.
- On accept, the block latches id, addr, len, size and burst, and sets the beat counter to 0.
- AW accepted -> WDATA. AR accepted -> RFETCH.
- Beat legality: a beat is illegal if burst is not INCR (01) or FIXED (00) -> SLVERR (10), with no RAM effect.
- Beat legality: a beat is out of range if addr[ADDR_W-1:DEPTH_LOG2+3] != BASE_ADDR[ADDR_W-1:DEPTH_LOG2+3] -> DECERR (11), with no RAM effect.
- Error checks are made per beat, so a burst that runs off the end of the window errors only on its out-of-range beats.
- Response aggregation: the write response is the worst code over all beats (DECERR > SLVERR > OKAY).
- Word index is addr[DEPTH_LOG2+2:3].
- Address update: INCR adds (1<<size) after each beat, with ADDR_W wrap-around. FIXED holds the address.
- Narrow sizes: w_strb selects the bytes written. Reads always return the full 64-bit word.
- WDATA: w_ready=1. Each w handshake writes the strobed bytes of the current word when the beat is legal, and increments the beat counter.
- WDATA end of burst: on the beat where counter==len, go to WRESP. If w_last disagrees with counter==len on any beat, the response becomes at least SLVERR. A stray w_last does not end the burst early.
- WRESP: b_valid=1, b_id = latched id, b_resp held stable until b_ready. Handshake -> IDLE.
- RFETCH: issue the RAM read for the current word. Next cycle -> RDATA.
- RDATA: r_valid=1 with r_data registered from the RAM, or 0 when the beat errors. r_resp is that beat's code; r_last=(counter==len); r_id = latched id.
- RDATA hold: all R outputs stay stable while r_ready=0.
- RDATA handshake: if last, go to IDLE; otherwise advance the address and counter and go to RFETCH.
- Read latency: ar handshake at cycle T gives r_valid at T+2; with r_ready held high, one beat every 2 cycles.
- Write throughput: one beat per cycle. b_valid rises in the cycle after the last w handshake.
- Same-cycle behaviour: no output depends combinationally on an input in the same cycle, except that the ready/valid signals are registered state.

Test Plan:
- Single write then read: AW addr 0x8000_0010, len 0, strb 0xFF, data 0x1122334455667788 -> b_resp 00 with id echoed; AR to the same address -> r_data 0x1122334455667788, r_last=1, r_valid at T+2.
- INCR burst: write len 3 from 0x8000_0100 with data 0,1,2,3 (b_resp 00), then read back len 3 with r_ready toggling 1/0 -> 4 beats of 0,1,2,3, r_last only on beat 4, data stable while stalled.
- Byte strobes: full write 0xFFFF..., then strb 0x0F with data 0 -> read returns 0xFFFFFFFF00000000.
- Errors: AR to 0x0000_1000 -> r_resp 11 and r_data 0. AW with burst=10 (WRAP) len 1 -> b_resp 10 and RAM unchanged. A len-3 write whose w_last comes on beat 2 -> b_resp 10.
- Arbitration: AW and AR both valid in the same cycle right after reset -> write granted first, read granted next; a repeated collision flips the order.
- Reset mid-burst: resetn low during the third beat of a len-7 read -> r_valid=0 next cycle, FSM in IDLE, a fresh AR is serviced normally.

Source files
------------

// File: rtl/axi4_bram_mem.sv
// rtl/axi4_bram_mem.sv - AXI4 responder backed by a 64-bit synchronous RAM
module axi4_bram_mem #(
    parameter int                ID_W       = 4,
    parameter int                ADDR_W     = 32,
    parameter int                DEPTH_LOG2 = 14,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h8000_0000
) (
    input  logic              clock,
    input  logic              resetn,

    input  logic              io_axi4_0_aw_valid,
    output logic              io_axi4_0_aw_ready,
    input  logic [ID_W-1:0]   io_axi4_0_aw_id,
    input  logic [ADDR_W-1:0] io_axi4_0_aw_addr,
    input  logic [7:0]        io_axi4_0_aw_len,
    input  logic [2:0]        io_axi4_0_aw_size,
    input  logic [1:0]        io_axi4_0_aw_burst,

    input  logic              io_axi4_0_w_valid,
    output logic              io_axi4_0_w_ready,
    input  logic [63:0]       io_axi4_0_w_data,
    input  logic [7:0]        io_axi4_0_w_strb,
    input  logic              io_axi4_0_w_last,

    output logic              io_axi4_0_b_valid,
    input  logic              io_axi4_0_b_ready,
    output logic [ID_W-1:0]   io_axi4_0_b_id,
    output logic [1:0]        io_axi4_0_b_resp,

    input  logic              io_axi4_0_ar_valid,
    output logic              io_axi4_0_ar_ready,
    input  logic [ID_W-1:0]   io_axi4_0_ar_id,
    input  logic [ADDR_W-1:0] io_axi4_0_ar_addr,
    input  logic [7:0]        io_axi4_0_ar_len,
    input  logic [2:0]        io_axi4_0_ar_size,
    input  logic [1:0]        io_axi4_0_ar_burst,

    output logic              io_axi4_0_r_valid,
    input  logic              io_axi4_0_r_ready,
    output logic [ID_W-1:0]   io_axi4_0_r_id,
    output logic [63:0]       io_axi4_0_r_data,
    output logic [1:0]        io_axi4_0_r_resp,
    output logic              io_axi4_0_r_last
);

    localparam int                DEPTH   = 1 << DEPTH_LOG2;
    localparam int                WIN_LSB = DEPTH_LOG2 + 3;
    localparam logic [ADDR_W-1:0] ONE     = 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    typedef enum logic [2:0] {
        IDLE,
        WDATA,
        WRESP,
        RFETCH,
        RDATA
    } state_t;

    state_t              state_q;
    logic                rr_rd_q;      // 1: read channel wins the next AW/AR collision
    logic [ID_W-1:0]     id_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [7:0]          len_q;
    logic [2:0]          size_q;
    logic [1:0]          burst_q;
    logic [7:0]          cnt_q;
    logic [1:0]          wresp_acc_q;  // worst code seen so far in the write burst

    logic                aw_ready_q;
    logic                ar_ready_q;
    logic                w_ready_q;
    logic                b_valid_q;
    logic [ID_W-1:0]     b_id_q;
    logic [1:0]          b_resp_q;
    logic                r_valid_q;
    logic [ID_W-1:0]     r_id_q;
    logic [63:0]         r_data_q;
    logic [1:0]          r_resp_q;
    logic                r_last_q;

    logic [63:0]         mem [DEPTH];

    logic [1:0]            beat_resp_d;
    logic [1:0]            w_beat_resp_d;
    logic [DEPTH_LOG2-1:0] word_idx_d;
    logic [ADDR_W-1:0]     addr_next_d;
    logic                  beat_last_d;
    logic                  w_fire_d;
    logic                  mem_we_d;

    function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
        // Codes in use order numerically: OKAY(00) < SLVERR(10) < DECERR(11)
        return (a > b) ? a : b;
    endfunction

    // Decode the current beat: legality, RAM word, next address, last flag
    always_comb begin
        beat_resp_d = RESP_OKAY;
        if (burst_q != BURST_FIXED && burst_q != BURST_INCR) begin
            beat_resp_d = RESP_SLVERR;
        end else if (addr_q[ADDR_W-1:WIN_LSB] != BASE_ADDR[ADDR_W-1:WIN_LSB]) begin
            beat_resp_d = RESP_DECERR;
        end
        word_idx_d  = addr_q[WIN_LSB-1:3];
        addr_next_d = (burst_q == BURST_INCR) ? addr_q + (ONE << size_q) : addr_q;
        beat_last_d = (cnt_q == len_q);
        w_fire_d    = (state_q == WDATA) && w_ready_q && io_axi4_0_w_valid;
        mem_we_d    = resetn && w_fire_d && (beat_resp_d == RESP_OKAY);
        // A w_last that disagrees with the beat count poisons the response
        w_beat_resp_d = beat_resp_d;
        if (io_axi4_0_w_last != beat_last_d) begin
            w_beat_resp_d = worst(beat_resp_d, RESP_SLVERR);
        end
    end

    // RAM write port: strobed bytes of the current word on a legal w beat
    always_ff @(posedge clock) begin
        if (mem_we_d) begin
            for (int b = 0; b < 8; b++) begin
                if (io_axi4_0_w_strb[b]) begin
                    mem[word_idx_d][b*8 +: 8] <= io_axi4_0_w_data[b*8 +: 8];
                end
            end
        end
    end

    // Transaction FSM: arbitration, burst sequencing and registered AXI outputs
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q     <= IDLE;
            rr_rd_q     <= 1'b0;
            id_q        <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            size_q      <= '0;
            burst_q     <= '0;
            cnt_q       <= '0;
            wresp_acc_q <= RESP_OKAY;
            aw_ready_q  <= 1'b0;
            ar_ready_q  <= 1'b0;
            w_ready_q   <= 1'b0;
            b_valid_q   <= 1'b0;
            b_id_q      <= '0;
            b_resp_q    <= '0;
            r_valid_q   <= 1'b0;
            r_id_q      <= '0;
            r_data_q    <= '0;
            r_resp_q    <= '0;
            r_last_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (aw_ready_q && io_axi4_0_aw_valid) begin
                        id_q        <= io_axi4_0_aw_id;
                        addr_q      <= io_axi4_0_aw_addr;
                        len_q       <= io_axi4_0_aw_len;
                        size_q      <= io_axi4_0_aw_size;
                        burst_q     <= io_axi4_0_aw_burst;
                        cnt_q       <= '0;
                        wresp_acc_q <= RESP_OKAY;
                        aw_ready_q  <= 1'b0;
                        w_ready_q   <= 1'b1;
                        rr_rd_q     <= ~rr_rd_q;
                        state_q     <= WDATA;
                    end else if (ar_ready_q && io_axi4_0_ar_valid) begin
                        id_q       <= io_axi4_0_ar_id;
                        addr_q     <= io_axi4_0_ar_addr;
                        len_q      <= io_axi4_0_ar_len;
                        size_q     <= io_axi4_0_ar_size;
                        burst_q    <= io_axi4_0_ar_burst;
                        cnt_q      <= '0;
                        ar_ready_q <= 1'b0;
                        rr_rd_q    <= ~rr_rd_q;
                        state_q    <= RFETCH;
                    end else if (!aw_ready_q && !ar_ready_q) begin
                        // Grant one channel; its ready stays up until the handshake
                        if (io_axi4_0_aw_valid && (!io_axi4_0_ar_valid || !rr_rd_q)) begin
                            aw_ready_q <= 1'b1;
                        end else if (io_axi4_0_ar_valid) begin
                            ar_ready_q <= 1'b1;
                        end
                    end
                end

                WDATA: begin
                    if (w_fire_d) begin
                        cnt_q       <= cnt_q + 8'd1;
                        addr_q      <= addr_next_d;
                        wresp_acc_q <= worst(wresp_acc_q, w_beat_resp_d);
                        if (beat_last_d) begin
                            w_ready_q <= 1'b0;
                            b_valid_q <= 1'b1;
                            b_id_q    <= id_q;
                            b_resp_q  <= worst(wresp_acc_q, w_beat_resp_d);
                            state_q   <= WRESP;
                        end
                    end
                end

                WRESP: begin
                    if (io_axi4_0_b_ready) begin
                        b_valid_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end

                RFETCH: begin
                    // Synchronous RAM read lands directly in the R data register
                    r_valid_q <= 1'b1;
                    r_id_q    <= id_q;
                    r_data_q  <= (beat_resp_d == RESP_OKAY) ? mem[word_idx_d] : 64'd0;
                    r_resp_q  <= beat_resp_d;
                    r_last_q  <= beat_last_d;
                    state_q   <= RDATA;
                end

                RDATA: begin
                    if (io_axi4_0_r_ready) begin
                        r_valid_q <= 1'b0;
                        if (r_last_q) begin
                            state_q <= IDLE;
                        end else begin
                            addr_q  <= addr_next_d;
                            cnt_q   <= cnt_q + 8'd1;
                            state_q <= RFETCH;
                        end
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign io_axi4_0_aw_ready = aw_ready_q;
    assign io_axi4_0_ar_ready = ar_ready_q;
    assign io_axi4_0_w_ready  = w_ready_q;
    assign io_axi4_0_b_valid  = b_valid_q;
    assign io_axi4_0_b_id     = b_id_q;
    assign io_axi4_0_b_resp   = b_resp_q;
    assign io_axi4_0_r_valid  = r_valid_q;
    assign io_axi4_0_r_id     = r_id_q;
    assign io_axi4_0_r_data   = r_data_q;
    assign io_axi4_0_r_resp   = r_resp_q;
    assign io_axi4_0_r_last   = r_last_q;

endmodule

// File: tb/tb_axi4_bram_mem.sv
// tb/tb_axi4_bram_mem.sv - scoreboard testbench for axi4_bram_mem
module tb_axi4_bram_mem;

    logic        clock;
    logic        resetn;
    logic        aw_valid, aw_ready;
    logic [3:0]  aw_id;
    logic [31:0] aw_addr;
    logic [7:0]  aw_len;
    logic [2:0]  aw_size;
    logic [1:0]  aw_burst;
    logic        w_valid, w_ready;
    logic [63:0] w_data;
    logic [7:0]  w_strb;
    logic        w_last;
    logic        b_valid, b_ready;
    logic [3:0]  b_id;
    logic [1:0]  b_resp;
    logic        ar_valid, ar_ready;
    logic [3:0]  ar_id;
    logic [31:0] ar_addr;
    logic [7:0]  ar_len;
    logic [2:0]  ar_size;
    logic [1:0]  ar_burst;
    logic        r_valid, r_ready;
    logic [3:0]  r_id;
    logic [63:0] r_data;
    logic [1:0]  r_resp;
    logic        r_last;

    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
        logic        stable;
    } rbeat_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } bresp_t;

    rbeat_t exp_r[$];
    rbeat_t obs_r[$];
    bresp_t exp_b[$];
    bresp_t obs_b[$];

    int checks = 0;
    int errors = 0;
    int rd_lat = 0;
    int b_wait = 0;

    axi4_bram_mem dut (
        .clock              (clock),
        .resetn             (resetn),
        .io_axi4_0_aw_valid (aw_valid),
        .io_axi4_0_aw_ready (aw_ready),
        .io_axi4_0_aw_id    (aw_id),
        .io_axi4_0_aw_addr  (aw_addr),
        .io_axi4_0_aw_len   (aw_len),
        .io_axi4_0_aw_size  (aw_size),
        .io_axi4_0_aw_burst (aw_burst),
        .io_axi4_0_w_valid  (w_valid),
        .io_axi4_0_w_ready  (w_ready),
        .io_axi4_0_w_data   (w_data),
        .io_axi4_0_w_strb   (w_strb),
        .io_axi4_0_w_last   (w_last),
        .io_axi4_0_b_valid  (b_valid),
        .io_axi4_0_b_ready  (b_ready),
        .io_axi4_0_b_id     (b_id),
        .io_axi4_0_b_resp   (b_resp),
        .io_axi4_0_ar_valid (ar_valid),
        .io_axi4_0_ar_ready (ar_ready),
        .io_axi4_0_ar_id    (ar_id),
        .io_axi4_0_ar_addr  (ar_addr),
        .io_axi4_0_ar_len   (ar_len),
        .io_axi4_0_ar_size  (ar_size),
        .io_axi4_0_ar_burst (ar_burst),
        .io_axi4_0_r_valid  (r_valid),
        .io_axi4_0_r_ready  (r_ready),
        .io_axi4_0_r_id     (r_id),
        .io_axi4_0_r_data   (r_data),
        .io_axi4_0_r_resp   (r_resp),
        .io_axi4_0_r_last   (r_last)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drives AW then len+1 W beats (data0 + beat index), then collects B into obs_b
    task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input logic [63:0] data0,
                             input logic [7:0] strb, input int last_at);
        int n;
        aw_id = id; aw_addr = addr; aw_len = len; aw_size = 3'd3; aw_burst = burst; aw_valid = 1'b1;
        n = 0;
        while (aw_ready !== 1'b1 && n < 50) begin @(negedge clock); n++; end
        if (n >= 50) begin
            checks++; errors++; aw_valid = 1'b0;
            $display("FAIL wr_aw_timeout: aw_ready=%b after 50 cycles, want 1", aw_ready);
            return;
        end
        @(negedge clock);
        aw_valid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            w_valid = 1'b1; w_data = data0 + 64'(i); w_strb = strb; w_last = (i == last_at);
            n = 0;
            while (w_ready !== 1'b1 && n < 50) begin @(negedge clock); n++; end
            if (n >= 50) begin
                checks++; errors++; w_valid = 1'b0; w_last = 1'b0;
                $display("FAIL wr_w_timeout: w_ready=%b at beat %0d, want 1", w_ready, i);
                return;
            end
            @(negedge clock);
        end
        w_valid = 1'b0; w_last = 1'b0;
        b_ready = 1'b1;
        n = 0;
        while (b_valid !== 1'b1 && n < 50) begin @(negedge clock); n++; end
        b_wait = n;
        if (n >= 50) begin
            checks++; errors++; b_ready = 1'b0;
            $display("FAIL wr_b_timeout: b_valid=%b after 50 cycles, want 1", b_valid);
            return;
        end
        obs_b.push_back('{id: b_id, resp: b_resp});
        @(negedge clock);
        b_ready = 1'b0;
    endtask

    // Drives AR and collects each R beat into obs_r; optional one-cycle stall per beat
    // and optional reset assertion while beat abort_beat is presented
    task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input bit stall, input int abort_beat);
        int n;
        rbeat_t snap;
        ar_id = id; ar_addr = addr; ar_len = len; ar_size = 3'd3; ar_burst = burst; ar_valid = 1'b1;
        n = 0;
        while (ar_ready !== 1'b1 && n < 50) begin @(negedge clock); n++; end
        if (n >= 50) begin
            checks++; errors++; ar_valid = 1'b0;
            $display("FAIL rd_ar_timeout: ar_ready=%b after 50 cycles, want 1", ar_ready);
            return;
        end
        @(negedge clock);
        ar_valid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            n = (b == 0) ? 1 : 0;
            while (r_valid !== 1'b1 && n < 50) begin @(negedge clock); n++; end
            if (n >= 50) begin
                checks++; errors++;
                $display("FAIL rd_r_timeout: r_valid=%b at beat %0d, want 1", r_valid, b);
                return;
            end
            if (b == 0) rd_lat = n;
            if (b == abort_beat) begin
                resetn = 1'b0; r_ready = 1'b0;
                @(negedge clock);
                return;
            end
            snap = '{id: r_id, data: r_data, resp: r_resp, last: r_last, stable: 1'b1};
            if (stall) begin
                r_ready = 1'b0;
                @(negedge clock);
                if (r_valid !== 1'b1 || r_id !== snap.id || r_data !== snap.data ||
                    r_resp !== snap.resp || r_last !== snap.last) snap.stable = 1'b0;
            end
            r_ready = 1'b1;
            @(negedge clock);
            r_ready = 1'b0;
            obs_r.push_back(snap);
        end
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        repeat (3) @(negedge clock);
        checks++; if (aw_ready !== 1'b0) begin errors++; $display("FAIL reset_aw_ready: got %b want 0", aw_ready); end
        checks++; if (ar_ready !== 1'b0) begin errors++; $display("FAIL reset_ar_ready: got %b want 0", ar_ready); end
        checks++; if (w_ready !== 1'b0) begin errors++; $display("FAIL reset_w_ready: got %b want 0", w_ready); end
        checks++; if (b_valid !== 1'b0) begin errors++; $display("FAIL reset_b_valid: got %b want 0", b_valid); end
        checks++; if (b_resp !== 2'b00) begin errors++; $display("FAIL reset_b_resp: got %b want 00", b_resp); end
        checks++; if (r_valid !== 1'b0) begin errors++; $display("FAIL reset_r_valid: got %b want 0", r_valid); end
        checks++; if (r_data !== 64'd0) begin errors++; $display("FAIL reset_r_data: got %h want 0", r_data); end
        checks++; if (r_last !== 1'b0) begin errors++; $display("FAIL reset_r_last: got %b want 0", r_last); end
        resetn = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_arb;
        rbeat_t eo, oo;
        bresp_t eb, ob;
        // Collision right after reset: write first, then the waiting read
        aw_id = 4'h1; aw_addr = 32'h8000_0400; aw_len = 8'd0; aw_size = 3'd3; aw_burst = 2'b01;
        ar_id = 4'h2; ar_addr = 32'h8000_0400; ar_len = 8'd0; ar_size = 3'd3; ar_burst = 2'b01;
        aw_valid = 1'b1; ar_valid = 1'b1;
        @(negedge clock);
        checks++; if (aw_ready !== 1'b1 || ar_ready !== 1'b0) begin
            errors++; $display("FAIL arb_first: got aw_ready=%b ar_ready=%b want 1 0", aw_ready, ar_ready);
        end
        exp_b.push_back('{id: 4'h1, resp: 2'b00});
        axi_write(4'h1, 32'h8000_0400, 8'd0, 2'b01, 64'hAAAA_0000_1111_2222, 8'hFF, 0);
        exp_r.push_back('{id: 4'h2, data: 64'hAAAA_0000_1111_2222, resp: 2'b00, last: 1'b1, stable: 1'b1});
        axi_read(4'h2, 32'h8000_0400, 8'd0, 2'b01, 1'b0, -1);
        // Lone write leaves the pointer on read for the next collision
        exp_b.push_back('{id: 4'h3, resp: 2'b00});
        axi_write(4'h3, 32'h8000_0408, 8'd0, 2'b01, 64'hBBBB_0000_3333_4444, 8'hFF, 0);
        aw_id = 4'h4; aw_addr = 32'h8000_0408; aw_len = 8'd0; aw_size = 3'd3; aw_burst = 2'b01;
        ar_id = 4'h5; ar_addr = 32'h8000_0408; ar_len = 8'd0; ar_size = 3'd3; ar_burst = 2'b01;
        aw_valid = 1'b1; ar_valid = 1'b1;
        @(negedge clock);
        checks++; if (ar_ready !== 1'b1 || aw_ready !== 1'b0) begin
            errors++; $display("FAIL arb_flip: got aw_ready=%b ar_ready=%b want 0 1", aw_ready, ar_ready);
        end
        exp_r.push_back('{id: 4'h5, data: 64'hBBBB_0000_3333_4444, resp: 2'b00, last: 1'b1, stable: 1'b1});
        axi_read(4'h5, 32'h8000_0408, 8'd0, 2'b01, 1'b0, -1);
        exp_b.push_back('{id: 4'h4, resp: 2'b00});
        axi_write(4'h4, 32'h8000_0408, 8'd0, 2'b01, 64'hCCCC_0000_5555_6666, 8'hFF, 0);
        exp_r.push_back('{id: 4'h6, data: 64'hCCCC_0000_5555_6666, resp: 2'b00, last: 1'b1, stable: 1'b1});
        axi_read(4'h6, 32'h8000_0408, 8'd0, 2'b01, 1'b0, -1);
        while (exp_b.size() != 0) begin
            eb = exp_b.pop_front(); checks++;
            if (obs_b.size() == 0) begin errors++; $display("FAIL arb_b: got nothing want %h", eb); end
            else begin ob = obs_b.pop_front(); if (ob !== eb) begin errors++; $display("FAIL arb_b: got %h want %h", ob, eb); end end
        end
        while (exp_r.size() != 0) begin
            eo = exp_r.pop_front(); checks++;
            if (obs_r.size() == 0) begin errors++; $display("FAIL arb_r: got nothing want %h", eo); end
            else begin oo = obs_r.pop_front(); if (oo !== eo) begin errors++; $display("FAIL arb_r: got %h want %h", oo, eo); end end
        end
        obs_b.delete(); obs_r.delete();
    endtask

    task automatic test_single;
        rbeat_t eo, oo;
        bresp_t eb, ob;
        exp_b.push_back('{id: 4'h3, resp: 2'b00});
        axi_write(4'h3, 32'h8000_0010, 8'd0, 2'b01, 64'h1122_3344_5566_7788, 8'hFF, 0);
        checks++; if (b_wait !== 0) begin errors++; $display("FAIL single_b_latency: got %0d extra cycles want 0", b_wait); end
        exp_r.push_back('{id: 4'h9, data: 64'h1122_3344_5566_7788, resp: 2'b00, last: 1'b1, stable: 1'b1});
        axi_read(4'h9, 32'h8000_0010, 8'd0, 2'b01, 1'b0, -1);
        checks++; if (rd_lat !== 2) begin errors++; $display("FAIL single_r_latency: got %0d want 2", rd_lat); end
        while (exp_b.size() != 0) begin
            eb = exp_b.pop_front(); checks++;
            if (obs_b.size() == 0) begin errors++; $display("FAIL single_b: got nothing want %h", eb); end
            else begin ob = obs_b.pop_front(); if (ob !== eb) begin errors++; $display("FAIL single_b: got %h want %h", ob, eb); end end
        end
        while (exp_r.size() != 0) begin
            eo = exp_r.pop_front(); checks++;
            if (obs_r.size() == 0) begin errors++; $display("FAIL single_r: got nothing want %h", eo); end
            else begin oo = obs_r.pop_front(); if (oo !== eo) begin errors++; $display("FAIL single_r: got %h want %h", oo, eo); end end
        end
        obs_b.delete(); obs_r.delete();
    endtask

    task automatic test_incr;
        rbeat_t eo, oo;
        bresp_t eb, ob;
        exp_b.push_back('{id: 4'h1, resp: 2'b00});
        axi_write(4'h1, 32'h8000_0100, 8'd3, 2'b01, 64'd0, 8'hFF, 3);
        for (int i = 0; i < 4; i++)
            exp_r.push_back('{id: 4'h2, data: 64'(i), resp: 2'b00, last: (i == 3), stable: 1'b1});
        axi_read(4'h2, 32'h8000_0100, 8'd3, 2'b01, 1'b1, -1);
        while (exp_b.size() != 0) begin
            eb = exp_b.pop_front(); checks++;
            if (obs_b.size() == 0) begin errors++; $display("FAIL incr_b: got nothing want %h", eb); end
            else begin ob = obs_b.pop_front(); if (ob !== eb) begin errors++; $display("FAIL incr_b: got %h want %h", ob, eb); end end
        end
        while (exp_r.size() != 0) begin
            eo = exp_r.pop_front(); checks++;
            if (obs_r.size() == 0) begin errors++; $display("FAIL incr_r: got nothing want %h", eo); end
            else begin oo = obs_r.pop_front(); if (oo !== eo) begin errors++; $display("FAIL incr_r: got %h want %h", oo, eo); end end
        end
        obs_b.delete(); obs_r.delete();
    endtask

    task automatic test_strobe;
        rbeat_t eo, oo;
        bresp_t eb, ob;
        exp_b.push_back('{id: 4'h5, resp: 2'b00});
        axi_write(4'h5, 32'h8000_0200, 8'd0, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0);
        exp_b.push_back('{id: 4'h6, resp: 2'b00});
        axi_write(4'h6, 32'h8000_0200, 8'd0, 2'b01, 64'd0, 8'h0F, 0);
        exp_r.push_back('{id: 4'h7, data: 64'hFFFF_FFFF_0000_0000, resp: 2'b00, last: 1'b1, stable: 1'b1});
        axi_read(4'h7, 32'h8000_0200, 8'd0, 2'b01, 1'b0, -1);
        while (exp_b.size() != 0) begin
            eb = exp_b.pop_front(); checks++;
            if (obs_b.size() == 0) begin errors++; $display("FAIL strobe_b: got nothing want %h", eb); end
            else begin ob = obs_b.pop_front(); if (ob !== eb) begin errors++; $display("FAIL strobe_b: got %h want %h", ob, eb); end end
        end
        while (exp_r.size() != 0) begin
            eo = exp_r.pop_front(); checks++;
            if (obs_r.size() == 0) begin errors++; $display("FAIL strobe_r: got nothing want %h", eo); end
            else begin oo = obs_r.pop_front(); if (oo !== eo) begin errors++; $display("FAIL strobe_r: got %h want %h", oo, eo); end end
        end
        obs_b.delete(); obs_r.delete();
    endtask

    task automatic test_errors;
        rbeat_t eo, oo;
        bresp_t eb, ob;
        // Read outside the window
        exp_r.push_back('{id: 4'h1, data: 64'd0, resp: 2'b11, last: 1'b1, stable: 1'b1});
        axi_read(4'h1, 32'h0000_1000, 8'd0, 2'b01, 1'b0, -1);
        // WRAP burst: SLVERR and the RAM keeps the earlier word
        exp_b.push_back('{id: 4'h2, resp: 2'b10});
        axi_write(4'h2, 32'h8000_0010, 8'd1, 2'b10, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 1);
        exp_r.push_back('{id: 4'h3, data: 64'h1122_3344_5566_7788, resp: 2'b00, last: 1'b1, stable: 1'b1});
        axi_read(4'h3, 32'h8000_0010, 8'd0, 2'b01, 1'b0, -1);
        // Early w_last on beat 2 of a len-3 burst
        exp_b.push_back('{id: 4'h4, resp: 2'b10});
        axi_write(4'h4, 32'h8000_0300, 8'd3, 2'b01, 64'd100, 8'hFF, 2);
        // Burst running off the top of the window errors only on the outside beat
        exp_b.push_back('{id: 4'h6, resp: 2'b11});
        axi_write(4'h6, 32'h8001_FFF8, 8'd1, 2'b01, 64'h55, 8'hFF, 1);
        exp_r.push_back('{id: 4'h7, data: 64'h55, resp: 2'b00, last: 1'b0, stable: 1'b1});
        exp_r.push_back('{id: 4'h7, data: 64'd0, resp: 2'b11, last: 1'b1, stable: 1'b1});
        axi_read(4'h7, 32'h8001_FFF8, 8'd1, 2'b01, 1'b0, -1);
        while (exp_b.size() != 0) begin
            eb = exp_b.pop_front(); checks++;
            if (obs_b.size() == 0) begin errors++; $display("FAIL err_b: got nothing want %h", eb); end
            else begin ob = obs_b.pop_front(); if (ob !== eb) begin errors++; $display("FAIL err_b: got %h want %h", ob, eb); end end
        end
        while (exp_r.size() != 0) begin
            eo = exp_r.pop_front(); checks++;
            if (obs_r.size() == 0) begin errors++; $display("FAIL err_r: got nothing want %h", eo); end
            else begin oo = obs_r.pop_front(); if (oo !== eo) begin errors++; $display("FAIL err_r: got %h want %h", oo, eo); end end
        end
        obs_b.delete(); obs_r.delete();
    endtask

    task automatic test_reset_mid;
        rbeat_t eo, oo;
        exp_r.push_back('{id: 4'h8, data: 64'd0, resp: 2'b00, last: 1'b0, stable: 1'b1});
        exp_r.push_back('{id: 4'h8, data: 64'd1, resp: 2'b00, last: 1'b0, stable: 1'b1});
        axi_read(4'h8, 32'h8000_0100, 8'd7, 2'b01, 1'b0, 2);
        checks++; if (r_valid !== 1'b0) begin errors++; $display("FAIL midrst_r_valid: got %b want 0", r_valid); end
        checks++; if (ar_ready !== 1'b0 || aw_ready !== 1'b0) begin
            errors++; $display("FAIL midrst_ready: got aw=%b ar=%b want 0 0", aw_ready, ar_ready);
        end
        resetn = 1'b1;
        @(negedge clock);
        exp_r.push_back('{id: 4'h9, data: 64'd2, resp: 2'b00, last: 1'b1, stable: 1'b1});
        axi_read(4'h9, 32'h8000_0110, 8'd0, 2'b01, 1'b0, -1);
        while (exp_r.size() != 0) begin
            eo = exp_r.pop_front(); checks++;
            if (obs_r.size() == 0) begin errors++; $display("FAIL midrst_r: got nothing want %h", eo); end
            else begin oo = obs_r.pop_front(); if (oo !== eo) begin errors++; $display("FAIL midrst_r: got %h want %h", oo, eo); end end
        end
        obs_r.delete();
    endtask

    initial begin
        resetn = 1'b0;
        aw_valid = 1'b0; aw_id = '0; aw_addr = '0; aw_len = '0; aw_size = '0; aw_burst = '0;
        w_valid = 1'b0; w_data = '0; w_strb = '0; w_last = 1'b0;
        b_ready = 1'b0;
        ar_valid = 1'b0; ar_id = '0; ar_addr = '0; ar_len = '0; ar_size = '0; ar_burst = '0;
        r_ready = 1'b0;
        test_reset();
        test_arb();
        test_single();
        test_incr();
        test_strobe();
        test_errors();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
